// File: rtl/gobou_pkg.sv
// Shared sizes, state encoding and bus types for the gobou fully-connected controller.
package gobou_pkg;

    localparam int N_PE    = 16;
    localparam int LWIDTH  = 10;
    localparam int IMGSIZE = 12;
    localparam int D_DRAIN = 8;
    localparam int LANE_W  = $clog2(N_PE) + 1;
    localparam int DRAIN_W = $clog2(D_DRAIN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NET,
        S_DRAIN,
        S_DONE
    } ctrl_core_state_t;

    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg;

    typedef struct packed {
        logic [LWIDTH-1:0]  total_in;
        logic [LWIDTH-1:0]  total_out;
        logic [IMGSIZE-1:0] in_offset;
        logic [IMGSIZE-1:0] net_offset;
        logic [IMGSIZE-1:0] out_offset;
    } layer_cfg_t;

    // Base of the final output group: floor((total_out-1)/N_PE)*N_PE.
    function automatic logic [LWIDTH-1:0] last_group_base(input logic [LWIDTH-1:0] total_out);
        logic [31:0] t;
        t = 32'(total_out) - 32'd1;
        last_group_base = LWIDTH'((t / 32'(N_PE)) * 32'(N_PE));
    endfunction

    function automatic logic [LANE_W-1:0] group_lanes(input logic [LWIDTH-1:0] total_out,
                                                      input logic [LWIDTH-1:0] base);
        logic [LWIDTH-1:0] rem;
        rem = total_out - base;
        if (rem >= LWIDTH'(N_PE)) group_lanes = LANE_W'(N_PE);
        else                      group_lanes = LANE_W'(rem);
    endfunction

endpackage

// File: rtl/ctrl_core_if.sv
// Host handshake, layer config and datapath/write-back bus of ctrl_core.
// CTRL_CORE_PAUSE_EN adds the pause input.
interface ctrl_core_if;
    import gobou_pkg::*;

    logic               req;
    logic               ack;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  total_out;
    logic [IMGSIZE-1:0] in_offset;
    logic [IMGSIZE-1:0] net_offset;
    logic [IMGSIZE-1:0] out_offset;
    ctrl_reg            out_ctrl;
    logic [IMGSIZE-1:0] mem_in_addr;
    logic [IMGSIZE-1:0] mem_net_addr;
    logic [IMGSIZE-1:0] out_addr;
    logic [LANE_W-1:0]  out_lanes;
    logic               wb_go;

`ifdef CTRL_CORE_PAUSE_EN
    logic               pause;

    modport master (output req, total_in, total_out, in_offset, net_offset, out_offset, pause,
                    input  ack, out_ctrl, mem_in_addr, mem_net_addr, out_addr, out_lanes, wb_go);
    modport slave  (input  req, total_in, total_out, in_offset, net_offset, out_offset, pause,
                    output ack, out_ctrl, mem_in_addr, mem_net_addr, out_addr, out_lanes, wb_go);
`else
    modport master (output req, total_in, total_out, in_offset, net_offset, out_offset,
                    input  ack, out_ctrl, mem_in_addr, mem_net_addr, out_addr, out_lanes, wb_go);
    modport slave  (input  req, total_in, total_out, in_offset, net_offset, out_offset,
                    output ack, out_ctrl, mem_in_addr, mem_net_addr, out_addr, out_lanes, wb_go);
`endif

endinterface

// File: rtl/ctrl_core_cnt.sv
// Wrapping up-counter; last pulses for one cycle after an enabled step taken at cnt==max.
module ctrl_core_cnt #(
    parameter int W    = 8,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            cnt  <= '0;
            last <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            last <= 1'b0;
        end else begin
            last <= en && (cnt == max);
            if (en) cnt <= (cnt == max) ? '0 : cnt + W'(STEP);
        end
    end

endmodule

// File: rtl/ctrl_core.sv
// Layer sequencer for the gobou FC datapath: streams beats per N_PE group, drains, triggers write-back.
// Optional stall input enabled by defining CTRL_CORE_PAUSE_EN.
module ctrl_core
    import gobou_pkg::*;
(
    input logic        clk,
    input logic        xrst,
    ctrl_core_if.slave bus
);

    ctrl_core_state_t   state, next_state;
    layer_cfg_t         cfg;
    logic               ack_q;
    logic               pause_w;
    logic               cfg_load, beat, drain_en, grp_step;
    logic [LWIDTH-1:0]  in_cnt, in_max, out_base;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               in_last, drain_last, out_last;
    logic [IMGSIZE-1:0] beat_total;
    logic               start_p1, valid_p1;
    logic [IMGSIZE-1:0] mem_in_addr_p1, mem_net_addr_p1, out_addr_q;
    logic [LANE_W-1:0]  out_lanes_q;

`ifdef CTRL_CORE_PAUSE_EN
    assign pause_w = bus.pause;
`else
    assign pause_w = 1'b0;
`endif

    assign in_max = cfg.total_in - LWIDTH'(1);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= S_IDLE;
            ack_q <= 1'b1;
        end else begin
            state <= next_state;
            ack_q <= (next_state == S_IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (ack_q && bus.req) begin
                    if (bus.total_in == '0 || bus.total_out == '0) next_state = S_DONE;
                    else                                           next_state = S_NET;
                end
            end
            S_NET:   if (beat && in_cnt == in_max) next_state = S_DRAIN;
            // drain_last marks the one-cycle hand-off where wb_go is high
            S_DRAIN: if (drain_last) next_state = out_last ? S_DONE : S_NET;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_load = (state == S_IDLE) && ack_q && bus.req;
        beat     = (state == S_NET) && !pause_w;
        drain_en = (state == S_DRAIN) && !drain_last;
        grp_step = drain_en && (drain_cnt == DRAIN_W'(D_DRAIN - 1));
    end

    ctrl_core_cnt #(.W(LWIDTH), .STEP(1)) u_in_cnt (
        .clk  (clk),
        .xrst (xrst),
        .clr  (state != S_NET),
        .en   (beat),
        .max  (in_max),
        .cnt  (in_cnt),
        .last (in_last)
    );

    ctrl_core_cnt #(.W(DRAIN_W), .STEP(1)) u_drain_cnt (
        .clk  (clk),
        .xrst (xrst),
        .clr  (state != S_DRAIN),
        .en   (drain_en),
        .max  (DRAIN_W'(D_DRAIN - 1)),
        .cnt  (drain_cnt),
        .last (drain_last)
    );

    // Steps at drain expiry so out_last is known in the hand-off cycle.
    ctrl_core_cnt #(.W(LWIDTH), .STEP(N_PE)) u_out_base (
        .clk  (clk),
        .xrst (xrst),
        .clr  (state == S_IDLE),
        .en   (grp_step),
        .max  (last_group_base(cfg.total_out)),
        .cnt  (out_base),
        .last (out_last)
    );

    // p0 -> p1: beat decode and addresses registered one cycle after the counter value
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            cfg             <= '0;
            beat_total      <= '0;
            start_p1        <= 1'b0;
            valid_p1        <= 1'b0;
            mem_in_addr_p1  <= '0;
            mem_net_addr_p1 <= '0;
            out_addr_q      <= '0;
            out_lanes_q     <= '0;
        end else begin
            if (cfg_load) begin
                cfg <= '{total_in:   bus.total_in,
                         total_out:  bus.total_out,
                         in_offset:  bus.in_offset,
                         net_offset: bus.net_offset,
                         out_offset: bus.out_offset};
                beat_total <= '0;
            end else if (beat) begin
                beat_total <= beat_total + IMGSIZE'(1);
            end
            valid_p1 <= beat;
            start_p1 <= beat && (in_cnt == '0);
            if (beat) begin
                mem_in_addr_p1  <= cfg.in_offset + IMGSIZE'(in_cnt);
                mem_net_addr_p1 <= cfg.net_offset + beat_total;
            end
            if (beat && in_cnt == '0) begin
                out_addr_q  <= cfg.out_offset + IMGSIZE'(out_base);
                out_lanes_q <= group_lanes(cfg.total_out, out_base);
            end
        end
    end

    assign bus.ack          = ack_q;
    assign bus.out_ctrl     = '{start: start_p1, valid: valid_p1, stop: in_last};
    assign bus.mem_in_addr  = mem_in_addr_p1;
    assign bus.mem_net_addr = mem_net_addr_p1;
    assign bus.out_addr     = out_addr_q;
    assign bus.out_lanes    = out_lanes_q;
    assign bus.wb_go        = drain_last;

endmodule

// File: tb/tb_ctrl_core.sv
// Self-checking bench for ctrl_core: vector table, directed corner sequences, random layers vs a list model.
module tb_ctrl_core;
    import gobou_pkg::*;

    localparam int MASK = (1 << IMGSIZE) - 1;
`ifdef CTRL_CORE_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    ctrl_core_if bus();
    ctrl_core dut (.clk(clk), .xrst(xrst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    typedef struct { int st, sp, ia, na, oa, ln; } beat_t;
    typedef struct { int oa, ln; } wb_t;
    typedef struct { int ti, to, ino, neto, outo, groups, last_lanes; } vec_t;

    beat_t obs_b[$];
    wb_t   obs_w[$];
    int    start_cyc[$], stop_cyc[$], wb_cyc[$];
    int    ack_cyc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_layer(input int ti, input int to, input int ino, input int neto, input int outo,
                             input bit hold_req, input bit perturb, input int ps, input int plen,
                             output int stalls);
        bit done;
        bit pz;
        obs_b.delete(); obs_w.delete();
        start_cyc.delete(); stop_cyc.delete(); wb_cyc.delete();
        ack_cyc = -1;
        stalls  = 0;
        done    = 1'b0;
        @(negedge clk);
        bus.total_in   = LWIDTH'(ti);
        bus.total_out  = LWIDTH'(to);
        bus.in_offset  = IMGSIZE'(ino);
        bus.net_offset = IMGSIZE'(neto);
        bus.out_offset = IMGSIZE'(outo);
        bus.req        = 1'b1;
        for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
            @(negedge clk);
            if (!hold_req) bus.req = 1'b0;
            if (perturb && cyc == 1) begin
                bus.total_in   = LWIDTH'(7);
                bus.total_out  = LWIDTH'(99);
                bus.in_offset  = IMGSIZE'('hABC);
                bus.net_offset = IMGSIZE'('h555);
                bus.out_offset = IMGSIZE'('h777);
            end
            pz = HAS_PAUSE && cyc >= ps && cyc < ps + plen;
            if (pz) stalls++;
`ifdef CTRL_CORE_PAUSE_EN
            bus.pause = pz;
`endif
            chk("ctrl_gate", int'((bus.out_ctrl.start | bus.out_ctrl.stop) & ~bus.out_ctrl.valid), 0);
            if (bus.out_ctrl.valid) begin
                obs_b.push_back('{int'(bus.out_ctrl.start), int'(bus.out_ctrl.stop),
                                  int'(bus.mem_in_addr), int'(bus.mem_net_addr),
                                  int'(bus.out_addr), int'(bus.out_lanes)});
                if (bus.out_ctrl.start) start_cyc.push_back(cyc);
                if (bus.out_ctrl.stop)  stop_cyc.push_back(cyc);
            end
            if (bus.wb_go) begin
                obs_w.push_back('{int'(bus.out_addr), int'(bus.out_lanes)});
                wb_cyc.push_back(cyc);
            end
            if (bus.ack) begin
                bus.req = 1'b0;
                ack_cyc = cyc;
                done    = 1'b1;
            end
        end
`ifdef CTRL_CORE_PAUSE_EN
        bus.pause = 1'b0;
`endif
        chk("layer_completes", int'(done), 1);
    endtask

    // Reference: the layer as ordered lists of beats and write-backs.
    task automatic verify(input int ti, input int to, input int ino, input int neto, input int outo,
                          input int stalls);
        beat_t eb[$];
        wb_t   ew[$];
        int    groups, run;
        groups = (ti == 0 || to == 0) ? 0 : (to + N_PE - 1) / N_PE;
        run = 0;
        for (int g = 0; g < groups; g++) begin
            int base, lanes, oa;
            base  = g * N_PE;
            lanes = (to - base < N_PE) ? to - base : N_PE;
            oa    = (outo + base) & MASK;
            for (int k = 0; k < ti; k++) begin
                eb.push_back('{int'(k == 0), int'(k == ti - 1), (ino + k) & MASK,
                               (neto + run) & MASK, oa, lanes});
                run++;
            end
            ew.push_back('{oa, lanes});
        end
        chk("beat_count", obs_b.size(), eb.size());
        for (int i = 0; i < eb.size() && i < obs_b.size(); i++) begin
            chk("beat_start", obs_b[i].st, eb[i].st);
            chk("beat_stop",  obs_b[i].sp, eb[i].sp);
            chk("in_addr",    obs_b[i].ia, eb[i].ia);
            chk("net_addr",   obs_b[i].na, eb[i].na);
            chk("out_addr_held",  obs_b[i].oa, eb[i].oa);
            chk("out_lanes_held", obs_b[i].ln, eb[i].ln);
        end
        chk("wb_count", obs_w.size(), ew.size());
        for (int i = 0; i < ew.size() && i < obs_w.size(); i++) begin
            chk("wb_out_addr",  obs_w[i].oa, ew[i].oa);
            chk("wb_out_lanes", obs_w[i].ln, ew[i].ln);
        end
        if (groups == 0) begin
            chk("ack_back_within_3", int'(ack_cyc >= 1 && ack_cyc <= 3), 1);
        end else begin
            if (wb_cyc.size() > 0) chk("ack_after_last_wb", ack_cyc - wb_cyc[$], 2);
            chk("start_count", start_cyc.size(), groups);
            chk("stop_count",  stop_cyc.size(), groups);
            for (int i = 1; i < start_cyc.size() && i <= stop_cyc.size(); i++)
                chk("group_gap", start_cyc[i] - stop_cyc[i-1] - 1, D_DRAIN + 1);
            if (start_cyc.size() > 0 && stop_cyc.size() > 0)
                chk("first_group_span", stop_cyc[0] - start_cyc[0], ti - 1 + stalls);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int stalls;
        int nv;
        bit found;

        vecs[0] = '{3,  16, 'h10,  'h100, 'h200, 1, 16};
        vecs[1] = '{2,  20, 'h0,   'h0,   'h0,   2, 4};
        vecs[2] = '{1,  16, 'h40,  'h80,  'h300, 1, 16};
        vecs[3] = '{0,  16, 'h10,  'h20,  'h30,  0, 0};
        vecs[4] = '{5,  0,  'h10,  'h20,  'h30,  0, 0};
        vecs[5] = '{4,  33, 'h7,   'h9,   'h11,  3, 1};
        vecs[6] = '{2,  32, 'hFFF, 'hFFE, 'hFF8, 2, 16};

        xrst = 1'b1;
        bus.req = 1'b0;
        bus.total_in = '0; bus.total_out = '0;
        bus.in_offset = '0; bus.net_offset = '0; bus.out_offset = '0;
`ifdef CTRL_CORE_PAUSE_EN
        bus.pause = 1'b0;
`endif
        #1 xrst = 1'b0;
        #1;
        chk("reset_ack",       int'(bus.ack), 1);
        chk("reset_ctrl",      int'(bus.out_ctrl), 0);
        chk("reset_wb_go",     int'(bus.wb_go), 0);
        chk("reset_out_lanes", int'(bus.out_lanes), 0);
        chk("reset_addrs",     int'(bus.mem_in_addr | bus.mem_net_addr | bus.out_addr), 0);
        @(negedge clk);
        @(negedge clk);
        xrst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_layer(vecs[i].ti, vecs[i].to, vecs[i].ino, vecs[i].neto, vecs[i].outo, 1'b0, 1'b0, 0, 0, stalls);
            verify(vecs[i].ti, vecs[i].to, vecs[i].ino, vecs[i].neto, vecs[i].outo, stalls);
            chk("vec_groups", obs_w.size(), vecs[i].groups);
            if (obs_w.size() > 0) chk("vec_last_lanes", obs_w[$].ln, vecs[i].last_lanes);
            if (i == 0 && obs_b.size() == 3 && obs_w.size() == 1) begin
                chk("basic_first_in_addr",  obs_b[0].ia, 'h10);
                chk("basic_last_net_addr",  obs_b[2].na, 'h102);
                chk("basic_wb_out_addr",    obs_w[0].oa, 'h200);
            end
        end

        // req held for the whole layer while config inputs are scrambled
        run_layer(3, 20, 'h30, 'h130, 'h230, 1'b1, 1'b1, 0, 0, stalls);
        verify(3, 20, 'h30, 'h130, 'h230, stalls);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("single_layer_ack",   int'(bus.ack), 1);
            chk("single_layer_valid", int'(bus.out_ctrl.valid), 0);
        end

        // asynchronous reset on beat 5 of a 10-beat group
        @(negedge clk);
        bus.total_in = LWIDTH'(10); bus.total_out = LWIDTH'(16);
        bus.in_offset = IMGSIZE'('h50); bus.net_offset = IMGSIZE'('h60); bus.out_offset = IMGSIZE'('h70);
        bus.req = 1'b1;
        nv = 0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (bus.out_ctrl.valid) nv++;
            if (nv == 6) found = 1'b1;
        end
        chk("rst_beat5_reached", int'(found), 1);
        #2 xrst = 1'b0;
        #1;
        chk("async_rst_ack",      int'(bus.ack), 1);
        chk("async_rst_ctrl",     int'(bus.out_ctrl), 0);
        chk("async_rst_wb_go",    int'(bus.wb_go), 0);
        chk("async_rst_in_addr",  int'(bus.mem_in_addr), 0);
        chk("async_rst_net_addr", int'(bus.mem_net_addr), 0);
        chk("async_rst_out_addr", int'(bus.out_addr), 0);
        chk("async_rst_lanes",    int'(bus.out_lanes), 0);
        @(negedge clk);
        xrst = 1'b1;
        run_layer(10, 16, 'h50, 'h60, 'h70, 1'b0, 1'b0, 0, 0, stalls);
        verify(10, 16, 'h50, 'h60, 'h70, stalls);

`ifdef CTRL_CORE_PAUSE_EN
        run_layer(6, 16, 'h20, 'h40, 'h60, 1'b0, 1'b0, 3, 3, stalls);
        verify(6, 16, 'h20, 'h40, 'h60, stalls);
        chk("pause_cycles", stalls, 3);
`endif

        for (int r = 0; r < 12; r++) begin
            int ti, to, ino, neto, outo;
            ti   = int'($urandom_range(1, 6));
            to   = int'($urandom_range(1, 50));
            ino  = int'($urandom_range(0, MASK));
            neto = int'($urandom_range(0, MASK));
            outo = int'($urandom_range(0, MASK));
            run_layer(ti, to, ino, neto, outo, 1'b0, 1'b0, 0, 0, stalls);
            verify(ti, to, ino, neto, outo, stalls);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_core.md
Name: ctrl_core

Overview:
- Top-level sequencer for the gobou fully-connected datapath.
- On a host request it walks every output-neuron group of N_PE lanes.
- For each group it streams total_in input/weight beats and drives the ctrl_bus (start/valid/stop) that feeds the MAC → bias → activation pipeline.
- After each group it waits for the pipeline to drain, then hands the group's output base address to the write-back stage.

Parameters:
- N_PE, 16: output neurons processed in parallel per group.
- LWIDTH, 10: width of layer-size fields total_in/total_out.
- IMGSIZE, 12: memory address width.
- D_DRAIN, 8: cycles from the last valid beat until the pipeline tail is clear; must be ≥ total ctrl pipeline depth.

Ports:
- clk  in  1  clock
- xrst  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  1  start layer; sampled only while ack=1
- ack  out  1  1 = idle/done, 0 = busy
- total_in  in  LWIDTH  input neurons
- total_out  in  LWIDTH  output neurons
- in_offset  in  IMGSIZE  input memory base
- net_offset  in  IMGSIZE  weight memory base
- out_offset  in  IMGSIZE  output memory base
- out_ctrl  ctrl_bus.out  3  start/valid/stop to datapath
- mem_in_addr  out  IMGSIZE  input read address
- mem_net_addr  out  IMGSIZE  weight read address (N_PE-wide word)
- out_addr  out  IMGSIZE  group output base, valid with wb_go
- out_lanes  out  $clog2(N_PE)+1  active lanes in current group
- wb_go  out  1  one-cycle write-back trigger

Behaviour:
- Reset values (asynchronous, xrst=0):
  - ack=1
  - out_ctrl={0,0,0}
  - all addresses 0
  - out_lanes=0
  - wb_go=0
  - state=S_IDLE
  - all counters 0
- Reset mid-operation aborts immediately. No stop and no wb_go are emitted.
- Config latch: in S_IDLE with ack=1 and req=1, latch all config inputs. Next cycle ack=0. Config changes while busy are ignored, and req while ack=0 is ignored.
- States:
  - S_IDLE → S_NET on req. If total_in=0 or total_out=0, go to S_DONE instead.
  - S_NET: one beat per cycle, in_cnt 0..total_in-1. On the last beat → S_DRAIN.
  - S_DRAIN: drain_cnt counts 0..D_DRAIN-1. On expiry, pulse wb_go. Then → S_NET if out_base+N_PE < total_out, else → S_DONE.
  - S_DONE: 1 cycle → S_IDLE, with ack=1 registered on entry to S_IDLE.
- Beat outputs are registered, 1 cycle after the state/counter value:
  - valid=1 every S_NET beat.
  - start=1 on the beat with in_cnt=0.
  - stop=1 on the beat with in_cnt=total_in-1.
  - total_in=1 → start and stop on the same beat.
- Addressing:
  - mem_in_addr = in_offset + in_cnt; restarts at in_offset each group.
  - mem_net_addr = net_offset + running beat count; continuous across groups, never reset within a layer. Widths truncate to IMGSIZE with no saturation.
  - out_addr = out_offset + out_base, where out_base steps by N_PE.
  - out_lanes = min(N_PE, total_out − out_base).
  - out_addr and out_lanes are held stable from group start until the next group starts.
- Group count = ceil(total_out/N_PE). The last group can be partial (e.g. out_lanes=4).
- Gap between groups: exactly D_DRAIN+1 idle cycles between a stop and the next start.
- Completion: ack rises exactly 2 cycles after the last wb_go.

Optional Feature:
- Macro CTRL_CORE_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in S_NET, in_cnt and the address counters hold, and valid/start/stop deassert.
  - The beat resumes unchanged on the cycle after pause=0.
  - pause has no effect in other states.
- Undefined: no port; S_NET never stalls.

Decomposition:
- Package gobou_pkg holds:
  - N_PE, LWIDTH, IMGSIZE, D_DRAIN
  - enum ctrl_core_state_t {S_IDLE, S_NET, S_DRAIN, S_DONE}
  - the existing ctrl_reg struct
- One natural sub-module: ctrl_core_cnt, a parameterised up-counter with clear, enable, max input and registered last flag. It is instantiated for in_cnt, drain_cnt and out_base.

Test Plan:
- Basic layer:
  - Stimulus: total_in=3, total_out=16, in_offset=0x10, net_offset=0x100, out_offset=0x200.
  - Response: one group; valid on 3 beats; start on beat 0, stop on beat 2; mem_in_addr 0x10..0x12; mem_net_addr 0x100..0x102; one wb_go with out_addr=0x200, out_lanes=16; ack high again 2 cycles later.
- Partial last group:
  - Stimulus: total_in=2, total_out=20.
  - Response: two groups; out_lanes 16 then 4; out_addr offsets 0, 16; mem_net_addr continues 0..3; D_DRAIN+1 gap between stop and next start.
- Degenerate sizes:
  - total_in=1 → start=stop=valid on the same single beat.
  - total_in=0 → no valid, no wb_go, ack back to 1 in 3 cycles.
- Protocol violations:
  - req held high for the whole layer, and offsets changed mid-run → exactly one layer executes using the original offsets.
- Reset mid-operation:
  - Assert xrst=0 asynchronously on beat 5 of total_in=10.
  - Required response: outputs clear without waiting for a clock edge; ack=1; a fresh req runs a full, correct layer.
- With CTRL_CORE_PAUSE_EN:
  - pause=1 for 3 cycles mid-stream of total_in=6 → exactly 6 valid beats, contiguous addresses, stop delayed by 3 cycles.
